// File: rtl/sp3_uplink_frame_packer.sv
// Uplink frame packer: captures a programmed number of 234-bit lpGBT user-data frames into a
// two-entry FIFO and streams each as eight 32-bit words on a valid/ready interface.
module sp3_uplink_frame_packer #(
  parameter bit DROP_FEC = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk20,
  input  logic             rst,
  input  logic             uplinkrdy_i,
  input  logic             uplinkFEC_i,
  input  logic [233:0]     uplinkUserData_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] n_frames_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] fec_cnt_o
);

  localparam int FRAME_W = 234;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   fec_cnt_q, fec_cnt_d;
  logic [1:0]         occ_q, occ_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [2:0]         word_idx_q, word_idx_d;

  logic [FRAME_W-1:0] buf_q [2];
  logic [FRAME_W-1:0] head_w;
  logic [31:0]        word_w [8];

  logic               valid_w;
  logic               xfer_w;
  logic               pop_w;
  logic               slot_w;
  logic               fec_hit_w;
  logic               cand_w;
  logic               accept_w;
  logic               drop_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Word slicing of the head entry; the top word carries only the 10 remaining payload bits.
  assign head_w = buf_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      if (gi < 7) begin : g_full
        assign word_w[gi] = head_w[32*gi +: 32];
      end else begin : g_tail
        assign word_w[gi] = {22'b0, head_w[FRAME_W-1:224]};
      end
    end
  endgenerate

  assign valid_w = (occ_q != 2'd0);
  assign xfer_w  = valid_w && m_ready;
  assign pop_w   = xfer_w && (word_idx_q == 3'd7);

  // A slot that frees on this edge lets a full buffer still take the incoming frame.
  assign slot_w    = (state_q == ST_CAPTURE) && (frame_cnt_q < n_q) && uplinkrdy_i;
  assign fec_hit_w = slot_w && DROP_FEC && uplinkFEC_i;
  assign cand_w    = slot_w && !fec_hit_w;
  assign accept_w  = cand_w && ((occ_q != 2'd2) || pop_w);
  assign drop_w    = cand_w && !accept_w;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    fec_cnt_d   = fec_cnt_q;
    occ_d       = occ_q + {1'b0, accept_w} - {1'b0, pop_w};
    wr_ptr_d    = accept_w ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = pop_w ? ~rd_ptr_q : rd_ptr_q;
    word_idx_d  = xfer_w ? word_idx_q + 3'd1 : word_idx_q;

    if (accept_w) begin
      frame_cnt_d = sat_inc(frame_cnt_q);
    end
    if (drop_w) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    if (fec_hit_w) begin
      fec_cnt_d = sat_inc(fec_cnt_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          n_d         = n_frames_i;
          frame_cnt_d = '0;
          drop_cnt_d  = '0;
          fec_cnt_d   = '0;
          state_d     = (n_frames_i == '0) ? ST_DRAIN : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (frame_cnt_q == n_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (occ_q == 2'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything: flush the stream but keep the statistics visible.
    if (abort_i) begin
      state_d     = ST_IDLE;
      n_d         = n_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      fec_cnt_d   = fec_cnt_q;
      occ_d       = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      word_idx_d  = 3'd0;
    end
  end

  always_ff @(posedge clk20 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      fec_cnt_q   <= '0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      word_idx_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      fec_cnt_q   <= fec_cnt_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      word_idx_q  <= word_idx_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk20) begin
    if (accept_w) begin
      buf_q[wr_ptr_q] <= uplinkUserData_i;
    end
  end

  assign m_valid     = valid_w;
  assign m_data      = valid_w ? word_w[word_idx_q] : 32'd0;
  assign m_last      = valid_w && (word_idx_q == 3'd7);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DRAIN) && (occ_q == 2'd0) && !abort_i;
  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign fec_cnt_o   = fec_cnt_q;

endmodule

// File: tb/tb_sp3_uplink_frame_packer.sv
// Bench for sp3_uplink_frame_packer: directed scenarios plus randomized captures, each cycle
// compared against a queue-based frame model; a second instance covers DROP_FEC=0.
module tb_sp3_uplink_frame_packer;

  logic         clk20 = 1'b0;
  logic         rst;
  logic         uplinkrdy_i, uplinkFEC_i, arm_i, abort_i, m_ready;
  logic [233:0] uplinkUserData_i;
  logic [15:0]  n_frames_i;
  logic         m_valid, m_last, busy_o, done_o;
  logic [31:0]  m_data;
  logic [15:0]  frame_cnt_o, drop_cnt_o, fec_cnt_o;

  logic         arm0_i, m_ready0;
  logic         m_valid0, m_last0, busy0, done0;
  logic [31:0]  m_data0;
  logic [15:0]  frame_cnt0, drop_cnt0, fec_cnt0;

  int checks = 0;
  int errors = 0;

  // Reference model: frames as a queue, word position as a plain counter, mode 0/1/2 = idle/capture/drain.
  int           md, mw;
  logic [15:0]  mn, mf, mdr, me;
  logic [233:0] mq[$];

  int           xfer_cnt, done_cnt;
  logic [31:0]  got_q[$];
  bit           col0;
  logic [31:0]  got0_q[$];
  int           last0_cnt, done0_cnt;

  sp3_uplink_frame_packer #(.DROP_FEC(1'b1), .CNT_W(16)) dut (
    .clk20(clk20), .rst(rst), .uplinkrdy_i(uplinkrdy_i), .uplinkFEC_i(uplinkFEC_i),
    .uplinkUserData_i(uplinkUserData_i), .arm_i(arm_i), .abort_i(abort_i),
    .n_frames_i(n_frames_i), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o),
    .drop_cnt_o(drop_cnt_o), .fec_cnt_o(fec_cnt_o)
  );

  sp3_uplink_frame_packer #(.DROP_FEC(1'b0), .CNT_W(16)) dut0 (
    .clk20(clk20), .rst(rst), .uplinkrdy_i(uplinkrdy_i), .uplinkFEC_i(uplinkFEC_i),
    .uplinkUserData_i(uplinkUserData_i), .arm_i(arm0_i), .abort_i(abort_i),
    .n_frames_i(n_frames_i), .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0),
    .m_last(m_last0), .busy_o(busy0), .done_o(done0), .frame_cnt_o(frame_cnt0),
    .drop_cnt_o(drop_cnt0), .fec_cnt_o(fec_cnt0)
  );

  initial forever #5 clk20 = ~clk20;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] word_of(input logic [233:0] f, input int k);
    if (k < 7) return f[32*k +: 32];
    return {22'b0, f[233:224]};
  endfunction

  function automatic logic [233:0] rand_frame();
    logic [233:0] p = '0;
    for (int i = 0; i < 8; i++) p = {p[201:0], 32'($urandom())};
    return p;
  endfunction

  task automatic model_reset();
    md = 0; mw = 0; mn = 0; mf = 0; mdr = 0; me = 0;
    mq.delete();
  endtask

  task automatic clear_stats();
    xfer_cnt = 0; done_cnt = 0;
    got_q.delete();
  endtask

  // One clock: compare outputs mid-cycle against the model, advance the model, return just after the edge.
  task automatic tick();
    bit          ev, xfer;
    logic [31:0] ed;
    int          old_md;
    logic [15:0] old_f;
    bit          old_empty;
    @(negedge clk20);
    ev = (mq.size() > 0);
    ed = ev ? word_of(mq[0], mw) : 32'd0;
    chk("m_valid", m_valid, ev);
    chk("m_data", m_data, ed);
    chk("m_last", m_last, ev && (mw == 7));
    chk("busy", busy_o, md != 0);
    chk("done", done_o, (md == 2) && (mq.size() == 0) && !abort_i);
    chk("frame_cnt", frame_cnt_o, mf);
    chk("drop_cnt", drop_cnt_o, mdr);
    chk("fec_cnt", fec_cnt_o, me);
    if (m_valid && m_ready) begin xfer_cnt++; got_q.push_back(m_data); end
    if (done_o) done_cnt++;
    if (col0 && m_valid0 && m_ready0) got0_q.push_back(m_data0);
    if (col0 && m_valid0 && m_ready0 && m_last0) last0_cnt++;
    if (col0 && done0) done0_cnt++;

    if (abort_i) begin
      md = 0; mw = 0;
      mq.delete();
    end else begin
      old_md = md; old_f = mf; old_empty = (mq.size() == 0);
      xfer = ev && m_ready;
      if (xfer) begin
        if (mw == 7) begin mw = 0; void'(mq.pop_front()); end
        else mw++;
      end
      if (old_md == 1 && old_f < mn && uplinkrdy_i) begin
        if (uplinkFEC_i) me = sat16(me);
        else if (mq.size() < 2) begin mq.push_back(uplinkUserData_i); mf = sat16(mf); end
        else mdr = sat16(mdr);
      end
      case (old_md)
        0: if (arm_i) begin
             mn = n_frames_i; mf = 0; mdr = 0; me = 0;
             md = (n_frames_i == 0) ? 2 : 1;
           end
        1: if (old_f == mn) md = 2;
        default: if (old_empty) md = 0;
      endcase
    end
    @(posedge clk20);
    #1;
  endtask

  task automatic arm(input logic [15:0] n);
    n_frames_i = n; arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic send(input logic [233:0] f, input logic fec);
    uplinkrdy_i = 1'b1; uplinkFEC_i = fec; uplinkUserData_i = f;
    tick();
    uplinkrdy_i = 1'b0; uplinkFEC_i = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    int c = 0;
    while (md != 0 && c < max) begin tick(); c++; end
    chk("busy_end", busy_o, 1'b0);
  endtask

  initial begin
    logic [233:0] d, f[4];
    int           stall;
    rst = 1'b1; uplinkrdy_i = 0; uplinkFEC_i = 0; uplinkUserData_i = '0; arm_i = 0;
    abort_i = 0; m_ready = 1; n_frames_i = 0; arm0_i = 0; m_ready0 = 1; col0 = 0;
    last0_cnt = 0; done0_cnt = 0;
    model_reset(); clear_stats();
    repeat (3) @(posedge clk20);
    #1;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cnt", {frame_cnt_o, drop_cnt_o, fec_cnt_o}, 48'd0);
    rst = 1'b0;

    // 1: single alternating-bit frame
    for (int k = 0; k < 234; k++) d[k] = (k % 2 == 1);
    clear_stats();
    arm(16'd1);
    send(d, 1'b0);
    run_until_idle(50);
    chk("t1_words", got_q.size(), 8);
    if (got_q.size() == 8) begin
      chk("t1_word0", got_q[0], 32'hAAAAAAAA);
      chk("t1_word7", got_q[7], 32'h000002AA);
    end
    chk("t1_done", done_cnt, 1);
    chk("t1_frames", frame_cnt_o, 16'd1);

    // 2: backpressure for 5 cycles at word 3
    clear_stats();
    arm(16'd1);
    send(rand_frame(), 1'b0);
    stall = -1;
    for (int c = 0; c < 60 && md != 0; c++) begin
      if (mq.size() > 0 && mw == 3 && stall < 0) stall = 5;
      if (stall > 0) begin m_ready = 1'b0; stall--; end
      else m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b1;
    chk("busy_end", busy_o, 1'b0);
    chk("t2_xfers", xfer_cnt, 8);

    // 3: continuous frames with incrementing payload
    clear_stats();
    arm(16'd4);
    uplinkrdy_i = 1'b1;
    for (int c = 0; c < 100 && md != 0; c++) begin
      uplinkUserData_i = 234'(c + 1);
      tick();
    end
    uplinkrdy_i = 1'b0;
    chk("busy_end", busy_o, 1'b0);
    chk("t3_words", got_q.size(), 32);
    chk("t3_drops", drop_cnt_o, 16'd13);
    for (int i = 1; i < 4; i++)
      if (got_q.size() == 32) chk("t3_order", got_q[8*i] > got_q[8*(i-1)], 1'b1);

    // 4: FEC pattern 1,0,1,0 on both instances
    for (int i = 0; i < 4; i++) f[i] = rand_frame();
    clear_stats(); got0_q.delete(); col0 = 1;
    arm0_i = 1'b1;
    arm(16'd2);
    arm0_i = 1'b0;
    for (int i = 0; i < 4; i++) send(f[i], (i % 2 == 0));
    run_until_idle(60);
    repeat (5) tick();
    col0 = 0;
    chk("t4_fec", fec_cnt_o, 16'd2);
    chk("t4_words", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("t4_f2w0", got_q[0], word_of(f[1], 0));
      chk("t4_f4w7", got_q[15], word_of(f[3], 7));
    end
    chk("t4_nf_words", got0_q.size(), 16);
    if (got0_q.size() == 16)
      for (int k = 0; k < 8; k++) begin
        chk("t4_nf_f1", got0_q[k], word_of(f[0], k));
        chk("t4_nf_f2", got0_q[8+k], word_of(f[1], k));
      end
    chk("t4_nf_cnts", {frame_cnt0, drop_cnt0, fec_cnt0}, {16'd2, 16'd0, 16'd0});
    chk("t4_nf_last", last0_cnt, 2);
    chk("t4_nf_done", done0_cnt, 1);
    chk("t4_nf_idle", {busy0, m_valid0}, 2'b00);

    // 5: abort during word 4 of DRAIN, then a clean frame
    clear_stats();
    arm(16'd1);
    send(rand_frame(), 1'b0);
    for (int c = 0; c < 20 && !(md == 2 && mq.size() > 0 && mw == 4); c++) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t5_valid", m_valid, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_nodone", done_cnt, 0);
    clear_stats();
    arm(16'd1);
    send(rand_frame(), 1'b0);
    run_until_idle(50);
    chk("t5_words", xfer_cnt, 8);
    chk("t5_done", done_cnt, 1);

    // 6: async reset with two buffered frames, then arm-while-busy is ignored
    m_ready = 1'b0;
    arm(16'd5);
    send(rand_frame(), 1'b0);
    send(rand_frame(), 1'b0);
    tick();
    chk("t6_occ", mq.size() == 2 && busy_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out", {m_valid, m_last, busy_o, done_o, m_data}, 36'd0);
    chk("t6_rst_cnt", {frame_cnt_o, drop_cnt_o, fec_cnt_o}, 48'd0);
    model_reset();
    @(posedge clk20);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    clear_stats();
    arm(16'd2);
    arm(16'd7);
    uplinkrdy_i = 1'b1;
    for (int c = 0; c < 80 && md != 0; c++) begin
      uplinkUserData_i = rand_frame();
      tick();
    end
    uplinkrdy_i = 1'b0;
    chk("busy_end", busy_o, 1'b0);
    chk("t6_frames", frame_cnt_o, 16'd2);
    chk("t6_done", done_cnt, 1);

    // Randomized captures
    for (int r = 0; r < 8; r++) begin
      arm(16'($urandom_range(1, 6)));
      for (int c = 0; c < 600 && md != 0; c++) begin
        uplinkrdy_i      = ($urandom_range(0, 9) < 7);
        uplinkFEC_i      = ($urandom_range(0, 3) == 0);
        uplinkUserData_i = rand_frame();
        m_ready          = ($urandom_range(0, 9) < 6);
        abort_i          = (r == 5 && c == 25);
        tick();
      end
      abort_i = 1'b0; uplinkrdy_i = 1'b0; m_ready = 1'b1;
      chk("busy_end", busy_o, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
